// File: rtl/fft_pkg.sv
// Shared FFT definitions: SFP word width, frame geometry, index bit reversal
// and the write/read state encodings used by the reorder stage.
package fft_pkg;

  localparam int NB   = 16;
  localparam int N    = 32;
  localparam int LOGN = 5;

  typedef logic [NB-1:0] sfp_t;

  typedef enum logic {
    IDLE,
    WRITE
  } wr_state_e;

  typedef enum logic {
    RIDLE,
    READ
  } rd_state_e;

  function automatic logic [LOGN-1:0] bitrev5(input logic [LOGN-1:0] a);
    logic [LOGN-1:0] r;
    for (int i = 0; i < LOGN; i++) begin
      r[i] = a[LOGN-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft32_digit_reorder_bank.sv
// One 32-entry bank: synchronous write port and a registered read port whose
// output register resets to zero so the stage outputs read 0 out of reset.
module reorder_bank #(
  parameter int W  = 32,
  parameter int AW = 5
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem [2**AW];

  always_ff @(posedge CLK) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Only the read register is reset; the array contents are left as they are.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/fft32_digit_reorder.sv
// Ping-pong reorder stage: frames arrive in bit-reversed order and are
// re-emitted in natural order, one bank written while the other is read.
module fft32_digit_reorder #(
  parameter int NB = fft_pkg::NB,
  parameter int N  = fft_pkg::N
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          START_I,
  input  logic [NB-1:0] DR,
  input  logic [NB-1:0] DI,
  output logic [NB-1:0] OR,
  output logic [NB-1:0] OI,
  output logic          RDY_O,
  output logic          VLD_O
);

  import fft_pkg::*;

  localparam logic [LOGN-1:0] LAST = LOGN'(N - 1);

  wr_state_e       ws, ws_nxt;
  logic [LOGN-1:0] wcnt, wcnt_nxt;
  logic            wb, wb_nxt;
  logic            we, handoff;

  rd_state_e       rs, rs_nxt;
  logic [LOGN-1:0] rcnt, rcnt_nxt;
  logic            rbank, rbank_nxt;
  logic            re;
  logic            rsel;

  logic [2*NB-1:0] rdata0, rdata1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ws   <= IDLE;
      wcnt <= '0;
      wb   <= 1'b0;
    end else begin
      ws   <= ws_nxt;
      wcnt <= wcnt_nxt;
      wb   <= wb_nxt;
    end
  end

  // A start during a partial frame restarts it in place; a start on the last
  // sample chains straight into the other bank.
  always_comb begin
    ws_nxt   = ws;
    wcnt_nxt = wcnt;
    wb_nxt   = wb;
    we       = 1'b0;
    handoff  = 1'b0;
    case (ws)
      IDLE: begin
        if (START_I) begin
          ws_nxt   = WRITE;
          wcnt_nxt = '0;
        end
      end
      WRITE: begin
        if (wcnt == LAST) begin
          we       = 1'b1;
          handoff  = 1'b1;
          wb_nxt   = ~wb;
          wcnt_nxt = '0;
          ws_nxt   = START_I ? WRITE : IDLE;
        end else if (START_I) begin
          wcnt_nxt = '0;
        end else begin
          we       = 1'b1;
          wcnt_nxt = wcnt + LOGN'(1);
        end
      end
      default: ws_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      rs    <= RIDLE;
      rcnt  <= '0;
      rbank <= 1'b0;
      rsel  <= 1'b0;
      RDY_O <= 1'b0;
      VLD_O <= 1'b0;
    end else begin
      rs    <= rs_nxt;
      rcnt  <= rcnt_nxt;
      rbank <= rbank_nxt;
      RDY_O <= handoff;
      VLD_O <= re;
      if (re) begin
        rsel <= rbank;
      end
    end
  end

  // A handoff may coincide with the final read of the previous frame, so it
  // takes priority over returning to idle.
  always_comb begin
    rs_nxt    = rs;
    rcnt_nxt  = rcnt;
    rbank_nxt = rbank;
    re        = 1'b0;
    if (rs == READ) begin
      re       = 1'b1;
      rcnt_nxt = rcnt + LOGN'(1);
      if (rcnt == LAST) begin
        rs_nxt = RIDLE;
      end
    end
    if (handoff) begin
      rs_nxt    = READ;
      rcnt_nxt  = '0;
      rbank_nxt = wb;
    end
  end

  reorder_bank #(.W(2*NB), .AW(LOGN)) u_bank0 (
    .CLK   (CLK),
    .RST   (RST),
    .we    (we & ~wb),
    .waddr (bitrev5(wcnt)),
    .wdata ({DR, DI}),
    .re    (re & ~rbank),
    .raddr (rcnt),
    .rdata (rdata0)
  );

  reorder_bank #(.W(2*NB), .AW(LOGN)) u_bank1 (
    .CLK   (CLK),
    .RST   (RST),
    .we    (we & wb),
    .waddr (bitrev5(wcnt)),
    .wdata ({DR, DI}),
    .re    (re & rbank),
    .raddr (rcnt),
    .rdata (rdata1)
  );

  assign OR = rsel ? rdata1[2*NB-1:NB] : rdata0[2*NB-1:NB];
  assign OI = rsel ? rdata1[NB-1:0]    : rdata0[NB-1:0];

endmodule

// File: tb/tb_fft32_digit_reorder.sv
// Self-checking bench for fft32_digit_reorder against a frame-level queue model.
module tb_fft32_digit_reorder;

  localparam int NB = 16;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          START_I = 1'b0;
  logic [NB-1:0] DR = '0;
  logic [NB-1:0] DI = '0;
  logic [NB-1:0] OR, OI;
  logic          RDY_O, VLD_O;

  int total = 0;
  int bad = 0;

  fft32_digit_reorder #(.NB(NB), .N(32)) dut (
    .CLK     (CLK),
    .RST     (RST),
    .START_I (START_I),
    .DR      (DR),
    .DI      (DI),
    .OR      (OR),
    .OI      (OI),
    .RDY_O   (RDY_O),
    .VLD_O   (VLD_O)
  );

  always #5 CLK = ~CLK;

  function automatic int refBitrev(input int v);
    int r = 0;
    int x = v;
    for (int i = 0; i < 5; i++) begin
      r = r * 2 + (x % 2);
      x = x / 2;
    end
    return r;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input bit start, input int dr, input int di);
    @(negedge CLK);
    START_I = start;
    DR = NB'(dr);
    DI = NB'(di);
  endtask

  // Frame-level model: collect samples, emit each completed frame in natural order.
  logic [31:0] expQ[$];
  logic [31:0] frameBuf[$];
  bit          collecting;
  logic        expVld, expRdy;
  logic [NB-1:0] expOr, expOi;

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      expQ.delete();
      frameBuf.delete();
      collecting = 0;
      expVld = 0;
      expRdy = 0;
      expOr = '0;
      expOi = '0;
    end else begin
      logic [31:0] d;
      expVld = 0;
      expRdy = 0;
      if (expQ.size() > 0) begin
        d = expQ.pop_front();
        expOr = d[31:16];
        expOi = d[15:0];
        expVld = 1;
      end
      if (collecting) begin
        if (START_I && frameBuf.size() < 31) begin
          frameBuf.delete();
        end else begin
          frameBuf.push_back({DR, DI});
          if (frameBuf.size() == 32) begin
            for (int k = 0; k < 32; k++) expQ.push_back(frameBuf[refBitrev(k)]);
            frameBuf.delete();
            expRdy = 1;
            collecting = START_I;
          end
        end
      end else if (START_I) begin
        collecting = 1;
        frameBuf.delete();
      end
    end
  end

  always @(negedge CLK) begin
    checkOutput("vld", {31'd0, VLD_O}, {31'd0, expVld});
    checkOutput("rdy", {31'd0, RDY_O}, {31'd0, expRdy});
    checkOutput("or", {16'd0, OR}, {16'd0, expOr});
    checkOutput("oi", {16'd0, OI}, {16'd0, expOi});
  end

  initial begin
    bit chain;
    bit chainNext;

    #3;
    checkOutput("reset_or", {16'd0, OR}, 32'd0);
    checkOutput("reset_vld", {31'd0, VLD_O}, 32'd0);
    checkOutput("reset_rdy", {31'd0, RDY_O}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;

    $display("[TB] single frame");
    applyStimulus(1, $urandom, $urandom);
    for (int n = 0; n < 32; n++) applyStimulus(0, refBitrev(n), 100 + refBitrev(n));
    repeat (40) applyStimulus(0, $urandom, $urandom);

    $display("[TB] back-to-back frames");
    applyStimulus(1, $urandom, $urandom);
    for (int f = 0; f < 3; f++)
      for (int n = 0; n < 32; n++)
        applyStimulus(n == 31 && f < 2, 32 * f + refBitrev(n), 100 + 32 * f + refBitrev(n));
    repeat (40) applyStimulus(0, $urandom, $urandom);

    $display("[TB] restart mid-frame");
    applyStimulus(1, $urandom, $urandom);
    for (int n = 0; n < 10; n++) applyStimulus(0, 500 + n, 600 + n);
    applyStimulus(1, $urandom, $urandom);
    for (int n = 0; n < 32; n++) applyStimulus(0, 200 + refBitrev(n), 300 + refBitrev(n));
    repeat (40) applyStimulus(0, $urandom, $urandom);

    $display("[TB] reset during read");
    applyStimulus(1, $urandom, $urandom);
    for (int n = 0; n < 32; n++) applyStimulus(0, 400 + refBitrev(n), 450 + refBitrev(n));
    repeat (5) applyStimulus(0, $urandom, $urandom);
    @(posedge CLK);
    #2;
    RST = 1'b0;
    #1;
    checkOutput("async_or", {16'd0, OR}, 32'd0);
    checkOutput("async_oi", {16'd0, OI}, 32'd0);
    checkOutput("async_vld", {31'd0, VLD_O}, 32'd0);
    checkOutput("async_rdy", {31'd0, RDY_O}, 32'd0);
    repeat (2) @(negedge CLK);
    RST = 1'b1;
    repeat (60) applyStimulus(0, $urandom, $urandom);

    $display("[TB] idle with random data");
    repeat (200) applyStimulus(0, $urandom, $urandom);

    $display("[TB] random frames");
    chain = 0;
    for (int f = 0; f < 4; f++) begin
      chainNext = (f < 3) && ($urandom_range(0, 1) == 1);
      if (!chain) applyStimulus(1, $urandom, $urandom);
      for (int n = 0; n < 32; n++) applyStimulus(n == 31 && chainNext, $urandom, $urandom);
      chain = chainNext;
      if (!chain) repeat ($urandom_range(0, 5)) applyStimulus(0, $urandom, $urandom);
    end
    repeat (40) applyStimulus(0, $urandom, $urandom);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
